univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit asynchronous-reset D flip-flop: a WIDTH-bit universal register.
- Modes: hold, shift right, shift left, parallel load. Optional rotate mode set by parameter.
- A saturating shift counter and a one-cycle done pulse let the block serve as a parallel-to-serial or serial-to-parallel converter in the W-series datapath exercises.

Parameters:
- WIDTH, 8: register width in bits; legal range is 2 or more.
- RESET_VAL, 0: value loaded into q on reset; WIDTH bits wide.
- ROTATE, 0: when 1, shifts rotate and sin_r/sin_l are ignored; when 0, shifts use the serial inputs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
- en  input  1  clock enable; when 0 the register, counter and done all hold (done drops to 0).
- clr  input  1  synchronous clear; effective only when en=1.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input; enters at q[WIDTH-1] on shift right.
- sin_l  input  1  serial input; enters at q[0] on shift left.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0]; the bit shifted out on shift right.
- sout_l  output  1  equals q[WIDTH-1]; the bit shifted out on shift left.
- shift_cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or clear; saturates at WIDTH.
- done  output  1  registered one-cycle pulse when shift_cnt reaches WIDTH.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - q=RESET_VAL, shift_cnt=0, done=0.
  - All three hold these values while reset is low.
  - Deassertion is synchronous in effect: first update occurs on the first rising edge after reset goes high.
- Priority at each rising edge: reset, then en=0 (hold), then clr, then mode.
- en=0: q and shift_cnt hold; done=0.
- en=1, clr=1: q=0 (not RESET_VAL), shift_cnt=0, done=0; mode is ignored.
- en=1, clr=0, mode=00: q and shift_cnt hold; done=0.
- mode=01 (shift right):
  - q <= {sin_r, q[WIDTH-1:1]}.
  - With ROTATE=1: q <= {q[0], q[WIDTH-1:1]}.
- mode=10 (shift left):
  - q <= {q[WIDTH-2:0], sin_l}.
  - With ROTATE=1: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- mode=11 (load): q <= d; shift_cnt=0; done=0.
- Shift counting (modes 01 and 10):
  - shift_cnt increments by 1 per shift, saturating at WIDTH.
  - Right and left shifts both count.
  - done=1 only on the edge where shift_cnt goes from WIDTH-1 to WIDTH; done=0 on every other edge.
  - While shift_cnt=WIDTH, further shifts still move q, but shift_cnt stays at WIDTH and done stays 0.
- Latency: one clock from inputs to q, shift_cnt and done.
- sout_r and sout_l are combinational from q; they carry no extra latency.
- Simultaneous events:
  - clr together with load or shift: clr wins.
  - reset asserted mid-shift-sequence: the sequence is abandoned and shift_cnt returns to 0; no done pulse is produced.
  - Inputs changing while en=0 have no effect.
- No X propagation from the unused serial input when ROTATE=1.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5: hold reset=0 for 10 time units mid-clock, then release -> q=A5 immediately (not at the next edge), shift_cnt=0, done=0; q stays A5 until the first enabled edge.
- Load d=8'h96 (en=1, mode=11), then 8 shift-rights with sin_r=0 -> sout_r sequence before each edge is 0,1,1,0,1,0,0,1; final q=00; shift_cnt=8; done high for exactly the cycle after the 8th edge.
- Load 8'h81, then 3 shift-lefts with sin_l=1 -> q=0F; shift_cnt=3; done=0. Then load 8'h00 -> shift_cnt=0.
- ROTATE=1: load 8'hC3, then 4 shift-rights -> q=3C; then 4 shift-lefts -> q=C3. shift_cnt=8 with one done pulse on the 8th shift; a 9th shift -> shift_cnt stays 8, done stays 0.
- en=0 with mode=01, sin_r=1 toggling for 5 edges -> q, shift_cnt unchanged; done=0. Then en=1, clr=1, mode=11, d=FF -> q=00, shift_cnt=0.
- Load 8'hFF, 5 shifts, then reset low for a partial cycle -> q=RESET_VAL, shift_cnt=0. 8 further shifts after release -> done pulses once at the 8th, not the 3rd.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// WIDTH-bit universal register: hold, shift right, shift left and parallel
// load, with optional rotate. A saturating shift counter and a one-cycle
// done pulse mark the point where a full word has been shifted through,
// so the block works as a parallel-to-serial or serial-to-parallel converter.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   en         clock enable (done forced low while en=0)
//   clr        synchronous clear to zero, only when en=1
//   mode       00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r      serial in at q[WIDTH-1] on shift right (ignored if ROTATE)
//   sin_l      serial in at q[0] on shift left (ignored if ROTATE)
//   d          parallel load data
//   q          register contents
//   sout_r     q[0]
//   sout_l     q[WIDTH-1]
//   shift_cnt  shifts since last load/clear/reset, saturates at WIDTH
//   done       one-cycle pulse on the shift that brings shift_cnt to WIDTH

module univ_shift_reg #(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter int                ROTATE    = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         clr,
   input  logic [1:0]                   mode,
   input  logic                         sin_r,
   input  logic                         sin_l,
   input  logic [WIDTH-1:0]             d,
   output logic [WIDTH-1:0]             q,
   output logic                         sout_r,
   output logic                         sout_l,
   output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
   output logic                         done
);

   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift_en;
   logic             fill_r;
   logic             fill_l;

   // Parameter-constant select: with ROTATE the serial inputs never reach
   // the datapath, so an undriven/X serial input cannot leak into q.
   assign fill_r = (ROTATE != 0) ? q_q[0]       : sin_r;
   assign fill_l = (ROTATE != 0) ? q_q[WIDTH-1] : sin_l;

   always_comb begin
      q_d      = q_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shift_en = 1'b0;
      if (en) begin
         if (clr) begin
            q_d   = '0;
            cnt_d = '0;
         end else begin
            case (mode)
               2'b01: begin
                  q_d      = {fill_r, q_q[WIDTH-1:1]};
                  shift_en = 1'b1;
               end
               2'b10: begin
                  q_d      = {q_q[WIDTH-2:0], fill_l};
                  shift_en = 1'b1;
               end
               2'b11: begin
                  q_d   = d;
                  cnt_d = '0;
               end
               default: begin
                  q_d = q_q;
               end
            endcase
            // Counter stops at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
            if (shift_en && (cnt_q != CNT_MAX)) begin
               cnt_d  = cnt_q + 1'b1;
               done_d = (cnt_q == (CNT_MAX - 1'b1));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q    <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q         = q_q;
   assign sout_r    = q_q[0];
   assign sout_l    = q_q[WIDTH-1];
   assign shift_cnt = cnt_q;
   assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

   logic       clk;
   logic       reset;
   logic       en;
   logic       clr;
   logic [1:0] mode;
   logic       sin_r;
   logic       sin_l;
   logic [7:0] d;

   logic [7:0] q0, q1;
   logic       sout_r0, sout_l0, sout_r1, sout_l1;
   logic [3:0] cnt0, cnt1;
   logic       done0, done1;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
      .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q0), .sout_r(sout_r0),
      .sout_l(sout_l0), .shift_cnt(cnt0), .done(done0));

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
      .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q1), .sout_r(sout_r1),
      .sout_l(sout_l1), .shift_cnt(cnt1), .done(done1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int q;
      int cnt;
      bit done;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   // Reference state per instance: index 0 = serial fill, 1 = rotate.
   int mq[2];
   int mc[2];

   int n_pass = 0;
   int n_total = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endfunction

   // Behavioural model: integer arithmetic on the word value.
   task automatic step(input logic e, input logic c, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [7:0] dd);
      en = e; clr = c; mode = m; sin_r = sr; sin_l = sl; d = dd;
      for (int k = 0; k < 2; k++) begin
         exp_t x;
         bit   shifted;
         shifted = 0;
         x.q = mq[k];
         x.cnt = mc[k];
         x.done = 0;
         if (e) begin
            if (c) begin
               x.q = 0;
               x.cnt = 0;
            end else if (m == 2'd1) begin
               x.q = mq[k] / 2 + 128 * ((k == 1) ? (mq[k] % 2) : int'(sr));
               shifted = 1;
            end else if (m == 2'd2) begin
               x.q = (mq[k] * 2) % 256 + ((k == 1) ? (mq[k] / 128) : int'(sl));
               shifted = 1;
            end else if (m == 2'd3) begin
               x.q = int'(dd);
               x.cnt = 0;
            end
            if (shifted) begin
               x.done = (mc[k] == 7);
               x.cnt = (mc[k] < 8) ? mc[k] + 1 : 8;
            end
         end
         mq[k] = x.q;
         mc[k] = x.cnt;
         if (k == 0) sb0.push_back(x);
         else        sb1.push_back(x);
      end
      @(negedge clk);
   endtask

   // Called at a negedge; reset spans one rising edge, released mid-cycle.
   task automatic do_reset();
      reset = 1'b0;
      #2;
      chk("rst_imm_q0", q0, 8'hA5);
      chk("rst_imm_q1", q1, 8'hA5);
      chk("rst_imm_cnt0", cnt0, 0);
      chk("rst_imm_done0", done0, 0);
      mq[0] = 'hA5; mq[1] = 'hA5; mc[0] = 0; mc[1] = 0;
      @(posedge clk);
      #2;
      chk("rst_hold_q0", q0, 8'hA5);
      chk("rst_hold_cnt1", cnt1, 0);
      #1 reset = 1'b1;
      @(negedge clk);
   endtask

   // Monitor: the register presents a new result every rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb0.size() > 0) begin
         e = sb0.pop_front();
         chk("mon_q0", q0, e.q);
         chk("mon_cnt0", cnt0, e.cnt);
         chk("mon_done0", done0, e.done);
         chk("mon_sout_r0", sout_r0, e.q % 2);
         chk("mon_sout_l0", sout_l0, e.q / 128);
      end
      if (sb1.size() > 0) begin
         e = sb1.pop_front();
         chk("mon_q1", q1, e.q);
         chk("mon_cnt1", cnt1, e.cnt);
         chk("mon_done1", done1, e.done);
         chk("mon_sout_r1", sout_r1, e.q % 2);
         chk("mon_sout_l1", sout_l1, e.q / 128);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] seq96;

   initial begin
      reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00;
      sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
      mq[0] = 'hA5; mq[1] = 'hA5; mc[0] = 0; mc[1] = 0;

      // Async reset mid-clock, held 10 time units.
      #2 reset = 1'b0;
      #1;
      chk("reset_q_immediate", q0, 8'hA5);
      chk("reset_cnt", cnt0, 0);
      chk("reset_done", done0, 0);
      #9 reset = 1'b1;
      #1;
      chk("release_q", q0, 8'hA5);
      chk("release_q_rot", q1, 8'hA5);
      @(negedge clk);
      chk("no_en_edge_q", q0, 8'hA5);
      step(0, 0, 2'd1, 1, 1, 8'h00);
      step(0, 0, 2'd2, 0, 1, 8'h00);

      // Load 96, eight right shifts with sin_r=0.
      step(1, 0, 2'd3, 0, 0, 8'h96);
      seq96 = 8'b1001_0110;
      for (int i = 0; i < 8; i++) begin
         chk("sout_r_seq", sout_r0, seq96[i]);
         step(1, 0, 2'd1, 0, 0, 8'h00);
      end
      chk("p2s_final_q", q0, 8'h00);
      chk("p2s_cnt", cnt0, 8);
      chk("p2s_done", done0, 1);
      step(1, 0, 2'd0, 0, 0, 8'h00);
      chk("p2s_done_drop", done0, 0);

      // Load 81, three left shifts with sin_l=1.
      step(1, 0, 2'd3, 0, 0, 8'h81);
      for (int i = 0; i < 3; i++) step(1, 0, 2'd2, 0, 1, 8'h00);
      chk("s2p_q", q0, 8'h0F);
      chk("s2p_cnt", cnt0, 3);
      chk("s2p_done", done0, 0);
      step(1, 0, 2'd3, 0, 0, 8'h00);
      chk("load_clears_cnt", cnt0, 0);

      // Rotate instance: C3 -> 3C -> C3, saturation on ninth shift.
      step(1, 0, 2'd3, 1, 1, 8'hC3);
      for (int i = 0; i < 4; i++) step(1, 0, 2'd1, 1, 0, 8'h00);
      chk("rot_right_q", q1, 8'h3C);
      for (int i = 0; i < 3; i++) step(1, 0, 2'd2, 0, 1, 8'h00);
      chk("rot_7_done", done1, 0);
      step(1, 0, 2'd2, 0, 1, 8'h00);
      chk("rot_left_q", q1, 8'hC3);
      chk("rot_cnt", cnt1, 8);
      chk("rot_done", done1, 1);
      step(1, 0, 2'd1, 0, 0, 8'h00);
      chk("sat_cnt", cnt1, 8);
      chk("sat_done", done1, 0);
      chk("sat_q_moves", q1, 8'hE1);

      // en=0 freezes everything, then clr beats load.
      for (int i = 0; i < 5; i++) step(0, 0, 2'd1, logic'(i % 2), 0, 8'h00);
      chk("en0_q", q1, 8'hE1);
      chk("en0_cnt", cnt1, 8);
      chk("en0_done", done1, 0);
      step(1, 1, 2'd3, 0, 0, 8'hFF);
      chk("clr_q", q0, 8'h00);
      chk("clr_cnt", cnt0, 0);

      // Reset mid-sequence abandons the count.
      step(1, 0, 2'd3, 0, 0, 8'hFF);
      for (int i = 0; i < 5; i++) step(1, 0, 2'd1, 1, 0, 8'h00);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 2'd2, 0, 1, 8'h00);
         if (i == 2) chk("after_rst_3rd_done", done0, 0);
      end
      chk("after_rst_8th_done", done0, 1);
      chk("after_rst_cnt", cnt0, 8);

      // Randomised traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 24) == 0),
              2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      @(negedge clk);
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
